sb_config_switch: RTL

Parametrised, self-configuring switch box for the PE tile; successor to the fixed 4-side × 4-track, 1-bit switch box. The block owns its own address match against `tile_id`, its per-output mux-select and pipeline-enable configuration registers, and a registered config readback path. Each output track either forwards or registers a selection from the same track on the other sides or from the tile's PE output.

---
 rtl/sb_config_switch_pkg.sv | 31 +++
 rtl/sb_config_switch_if.sv | 21 ++
 rtl/sb_config_switch_output_mux.sv | 54 +++++
 rtl/sb_config_switch.sv | 123 ++++++++++++
 4 files changed

// File: rtl/sb_config_switch_pkg.sv
// Shared constants and elaboration-time helpers for the self-configuring switch box.
// Field sizing is derived from the side count so the top and the output muxes agree.
package sb_pkg;

   localparam int unsigned TILE_LSB = 0;
   localparam int unsigned TILE_MSB = 15;
   localparam int unsigned IDX_LSB  = 16;
   localparam int unsigned IDX_MSB  = 23;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result = 0;
      while ((32'd1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

   // One field per output: mux select plus the pipeline-enable bit on top.
   function automatic int unsigned field_w(input int unsigned num_sides);
      return clog2(num_sides) + 1;
   endfunction

   function automatic int unsigned fields_per_word(input int unsigned num_sides);
      return 32 / field_w(num_sides);
   endfunction

endpackage

// File: rtl/sb_config_switch_if.sv
// Config bus of the switch box: write/read strobes in, registered readback out.
interface sb_config_switch_if;

   logic [31:0] config_addr;
   logic [31:0] config_data;
   logic        config_we;
   logic        config_re;
   logic [31:0] read_data;
   logic        read_valid;

   modport master (
      output config_addr, config_data, config_we, config_re,
      input  read_data, read_valid
   );

   modport slave (
      input  config_addr, config_data, config_we, config_re,
      output read_data, read_valid
   );

endinterface

// File: rtl/sb_config_switch_output_mux.sv
// One output track: picks the same track from another side or the PE result, and
// optionally presents it through a pipeline register that is reloaded every cycle.
module sb_output_mux
   import sb_pkg::*;
#(
   parameter int unsigned NUM_SIDES   = 4,
   parameter int unsigned TRACK_WIDTH = 1,
   parameter int unsigned SIDE        = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_SIDES*TRACK_WIDTH-1:0] track_in,
   input  logic [TRACK_WIDTH-1:0]           pe_output,
   input  logic [clog2(NUM_SIDES)-1:0]      sel,
   input  logic                             reg_en,
   output logic [TRACK_WIDTH-1:0]           out
);

   localparam int unsigned SEL_W   = clog2(NUM_SIDES);
   localparam int unsigned NUM_SEL = 1 << SEL_W;

   logic [TRACK_WIDTH-1:0] cand [NUM_SEL];
   logic [TRACK_WIDTH-1:0] mux_val;
   logic [TRACK_WIDTH-1:0] pipe_q;

   // Select k walks the other sides in ascending order, skipping our own side.
   for (genvar k = 0; k < NUM_SEL; k++) begin : g_cand
      if (k < NUM_SIDES - 1) begin : g_other
         localparam int unsigned SRC = (k < SIDE) ? k : k + 1;
         assign cand[k] = track_in[SRC*TRACK_WIDTH +: TRACK_WIDTH];
      end else if (k == NUM_SIDES - 1) begin : g_pe
         assign cand[k] = pe_output;
      end else begin : g_zero
         assign cand[k] = '0;
      end
   end

   assign mux_val = cand[sel];

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= mux_val;
      end
   end

   assign out = reg_en ? pipe_q : mux_val;

   // A track never routes back to its own side.
   logic unused_own;
   assign unused_own = ^track_in[SIDE*TRACK_WIDTH +: TRACK_WIDTH];

endmodule

// File: rtl/sb_config_switch.sv
// Self-configuring switch box: address decode against tile_id, per-output config fields
// packed into 32-bit words, registered readback, and one output mux per track.
module sb_config_switch
   import sb_pkg::*;
#(
   parameter int unsigned NUM_SIDES      = 4,
   parameter int unsigned NUM_TRACKS     = 4,
   parameter int unsigned TRACK_WIDTH    = 1,
   parameter int unsigned CONFIG_ID_BASE = 0
) (
   input  logic                                        clk,
   input  logic                                        reset,
   sb_config_switch_if.slave                           cfg,
   input  logic [15:0]                                 tile_id,
   input  logic [NUM_SIDES*NUM_TRACKS*TRACK_WIDTH-1:0] in_wires,
   input  logic [TRACK_WIDTH-1:0]                      pe_output,
   output logic [NUM_SIDES*NUM_TRACKS*TRACK_WIDTH-1:0] out_wires
);

   localparam int unsigned SEL_W           = clog2(NUM_SIDES);
   localparam int unsigned FIELD_W         = field_w(NUM_SIDES);
   localparam int unsigned FIELDS_PER_WORD = fields_per_word(NUM_SIDES);
   localparam int unsigned NUM_OUTS        = NUM_SIDES * NUM_TRACKS;
   localparam int unsigned NUM_WORDS       = ceil_div(NUM_OUTS, FIELDS_PER_WORD);

   if (NUM_SIDES < 2) begin : g_bad_sides
      $error("sb_config_switch needs at least two sides");
   end
   if (NUM_WORDS + CONFIG_ID_BASE > 256) begin : g_bad_words
      $error("sb_config_switch config words exceed the 8-bit index space");
   end

   logic [8:0]         idx_rel;
   logic [7:0]         word_idx;
   logic               hit;
   logic               wr_en;
   logic               rd_en;
   logic [FIELD_W-1:0] cfg_q [NUM_OUTS];
   logic [FIELD_W-1:0] cfg_d [NUM_OUTS];
   logic [31:0]        rd_word;
   logic [31:0]        read_data_q, read_data_d;
   logic               read_valid_q, read_valid_d;

   // Indices below the base wrap to >= 257, so one compare covers both bounds.
   assign idx_rel  = {1'b0, cfg.config_addr[IDX_MSB:IDX_LSB]} - 9'(CONFIG_ID_BASE);
   assign word_idx = idx_rel[7:0];
   assign hit      = (cfg.config_addr[TILE_MSB:TILE_LSB] == tile_id) &&
                     (idx_rel < 9'(NUM_WORDS));
   assign wr_en    = cfg.config_we && hit;
   assign rd_en    = cfg.config_re && hit;

   // Config is held per field, so unused word bits are never stored.
   always_comb begin
      cfg_d = cfg_q;
      for (int o = 0; o < NUM_OUTS; o++) begin
         if (wr_en && word_idx == 8'(o / FIELDS_PER_WORD)) begin
            cfg_d[o] = cfg.config_data[(o % FIELDS_PER_WORD)*FIELD_W +: FIELD_W];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int o = 0; o < NUM_OUTS; o++) begin
         if (word_idx == 8'(o / FIELDS_PER_WORD)) begin
            rd_word[(o % FIELDS_PER_WORD)*FIELD_W +: FIELD_W] = cfg_q[o];
         end
      end
   end

   always_comb begin
      read_valid_d = rd_en;
      read_data_d  = rd_en ? rd_word : read_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q        <= '{default: '0};
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
      end else begin
         cfg_q        <= cfg_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
      end
   end

   assign cfg.read_data  = read_data_q;
   assign cfg.read_valid = read_valid_q;

   // Track t of every side, gathered once and shared by all outputs on track t.
   logic [NUM_SIDES*TRACK_WIDTH-1:0] track_bus [NUM_TRACKS];

   for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_bus
      for (genvar k = 0; k < NUM_SIDES; k++) begin : g_side
         assign track_bus[t][k*TRACK_WIDTH +: TRACK_WIDTH] =
            in_wires[(k*NUM_TRACKS+t)*TRACK_WIDTH +: TRACK_WIDTH];
      end
   end

   for (genvar s = 0; s < NUM_SIDES; s++) begin : g_out_side
      for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_out_track
         localparam int unsigned O = s * NUM_TRACKS + t;
         sb_output_mux #(
            .NUM_SIDES   (NUM_SIDES),
            .TRACK_WIDTH (TRACK_WIDTH),
            .SIDE        (s)
         ) u_mux (
            .clk       (clk),
            .reset     (reset),
            .track_in  (track_bus[t]),
            .pe_output (pe_output),
            .sel       (cfg_q[O][SEL_W-1:0]),
            .reg_en    (cfg_q[O][SEL_W]),
            .out       (out_wires[O*TRACK_WIDTH +: TRACK_WIDTH])
         );
      end
   end

   logic unused_cfg;
   assign unused_cfg = ^{cfg.config_addr[31:24], cfg.config_data};

endmodule
